// File: rtl/ip_stride_multi_if.sv
// Request/prefetch bus of ip_stride_multi: the sample input and the prefetch issue port.
// Valid/ready: a transfer happens on a clock edge where valid and ready are both high;
// valid and its payload stay stable until that edge, and ready may depend on state only.
interface ip_stride_multi_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] ip_i;
  logic              pref_valid_o;
  logic [ADDR_W-1:0] pref_addr_o;
  logic              pref_ready_i;

  modport master (
    output req_valid_i, addr_i, ip_i, pref_ready_i,
    input  req_ready_o, pref_valid_o, pref_addr_o
  );

  modport slave (
    input  req_valid_i, addr_i, ip_i, pref_ready_i,
    output req_ready_o, pref_valid_o, pref_addr_o
  );
endinterface

// File: rtl/ip_stride_multi.sv
// IP-indexed stride prefetcher with per-tracker confidence, true-LRU replacement and a
// serial prefetch issue port. Define IP_STRIDE_STATS_EN for issue/drop counter ports.
module ip_stride_multi #(
  parameter int IP_TRACKER_COUNT = 16,
  parameter int DEGREE           = 4,
  parameter int CONF_BITS        = 2,
  parameter int CONF_THRESH      = 2,
  parameter int ADDR_W           = 64,
  parameter int LOG2_BLOCK_SIZE  = 6,
  parameter int LOG2_PAGE_SIZE   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IP_STRIDE_STATS_EN
  output logic [31:0] pf_issue_cnt_o,
  output logic [31:0] pf_drop_cnt_o,
`endif
  output logic        dbg_state_o,
  ip_stride_multi_if.slave bus
);
  localparam int CLA_W  = ADDR_W - LOG2_BLOCK_SIZE;
  localparam int PAGE_W = ADDR_W - LOG2_PAGE_SIZE;
  localparam int AGE_W  = $clog2(IP_TRACKER_COUNT);
  localparam int KW     = $clog2(DEGREE + 1);
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  logic                 valid_q       [IP_TRACKER_COUNT];
  logic                 valid_d       [IP_TRACKER_COUNT];
  logic [ADDR_W-1:0]    ip_q          [IP_TRACKER_COUNT];
  logic [ADDR_W-1:0]    ip_d          [IP_TRACKER_COUNT];
  logic [CLA_W-1:0]     last_cla_q    [IP_TRACKER_COUNT];
  logic [CLA_W-1:0]     last_cla_d    [IP_TRACKER_COUNT];
  logic [CLA_W-1:0]     last_stride_q [IP_TRACKER_COUNT];
  logic [CLA_W-1:0]     last_stride_d [IP_TRACKER_COUNT];
  logic [CONF_BITS-1:0] conf_q        [IP_TRACKER_COUNT];
  logic [CONF_BITS-1:0] conf_d        [IP_TRACKER_COUNT];
  logic [AGE_W-1:0]     age_q         [IP_TRACKER_COUNT];
  logic [AGE_W-1:0]     age_d         [IP_TRACKER_COUNT];

  state_t            state_q, state_d;
  logic [CLA_W-1:0]  cur_cla_q, cur_cla_d;
  logic [CLA_W-1:0]  stride_q, stride_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [KW-1:0]     k_q, k_d;
  logic              pref_valid_q, pref_valid_d;
  logic [ADDR_W-1:0] pref_addr_q, pref_addr_d;

  logic [CLA_W-1:0]     cla, stride, cand1_cla, nxt_cla;
  logic [PAGE_W-1:0]    page_in;
  logic [ADDR_W-1:0]    cand1_addr, nxt_addr;
  logic [AGE_W-1:0]     hit_idx, free_idx, lru_idx, sel_idx;
  logic [CONF_BITS-1:0] conf_cur, conf_upd;
  logic                 accept, hit, any_free, stride_nz, same_stride, trigger;
  logic                 cand1_in_page, nxt_in_page, hs, last_k;

  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.pref_valid_o = pref_valid_q;
  assign bus.pref_addr_o  = pref_addr_q;
  assign dbg_state_o      = (state_q == ST_ISSUE);

  assign cla     = CLA_W'(bus.addr_i >> LOG2_BLOCK_SIZE);
  assign page_in = PAGE_W'(bus.addr_i >> LOG2_PAGE_SIZE);
  assign accept  = bus.req_valid_i && (state_q == ST_IDLE);

  // Descending scan so the lowest matching index wins for the free slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = IP_TRACKER_COUNT - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == bus.ip_i)) begin
        hit     = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = AGE_W'(i);
      end
      if (age_q[i] == AGE_W'(IP_TRACKER_COUNT - 1)) lru_idx = AGE_W'(i);
    end
  end

  assign sel_idx     = hit ? hit_idx : (any_free ? free_idx : lru_idx);
  assign stride      = cla - last_cla_q[hit_idx];
  assign stride_nz   = |stride;
  assign same_stride = (stride == last_stride_q[hit_idx]);
  assign conf_cur    = conf_q[hit_idx];
  assign conf_upd    = same_stride ? ((conf_cur == CONF_MAX) ? conf_cur : conf_cur + 1'b1)
                                   : ((conf_cur == '0) ? conf_cur : conf_cur - 1'b1);
  assign trigger     = accept && hit && stride_nz && same_stride &&
                       (conf_upd >= CONF_BITS'(CONF_THRESH));

  assign cand1_cla     = cla + stride;
  assign cand1_addr    = {cand1_cla, {LOG2_BLOCK_SIZE{1'b0}}};
  assign cand1_in_page = (PAGE_W'(cand1_addr >> LOG2_PAGE_SIZE) == page_in);
  assign nxt_cla       = cur_cla_q + stride_q;
  assign nxt_addr      = {nxt_cla, {LOG2_BLOCK_SIZE{1'b0}}};
  assign nxt_in_page   = (PAGE_W'(nxt_addr >> LOG2_PAGE_SIZE) == page_q);
  assign hs            = (state_q == ST_ISSUE) && pref_valid_q && bus.pref_ready_i;
  assign last_k        = (k_q == KW'(DEGREE));

  always_comb begin
    valid_d       = valid_q;
    ip_d          = ip_q;
    last_cla_d    = last_cla_q;
    last_stride_d = last_stride_q;
    conf_d        = conf_q;
    age_d         = age_q;
    if (accept) begin
      if (hit) begin
        if (stride_nz) begin
          conf_d[hit_idx]        = conf_upd;
          last_cla_d[hit_idx]    = cla;
          last_stride_d[hit_idx] = stride;
        end
      end else begin
        valid_d[sel_idx]       = 1'b1;
        ip_d[sel_idx]          = bus.ip_i;
        last_cla_d[sel_idx]    = cla;
        last_stride_d[sel_idx] = '0;
        conf_d[sel_idx]        = '0;
      end
      // Younger entries age by one; the touched entry becomes most recent.
      for (int i = 0; i < IP_TRACKER_COUNT; i++) begin
        if (AGE_W'(i) == sel_idx)             age_d[i] = '0;
        else if (age_q[i] < age_q[sel_idx])   age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_cla_d    = cur_cla_q;
    stride_d     = stride_q;
    page_d       = page_q;
    k_d          = k_q;
    pref_valid_d = pref_valid_q;
    pref_addr_d  = pref_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger && cand1_in_page) begin
          state_d      = ST_ISSUE;
          cur_cla_d    = cand1_cla;
          stride_d     = stride;
          page_d       = page_in;
          k_d          = KW'(1);
          pref_valid_d = 1'b1;
          pref_addr_d  = cand1_addr;
        end
      end
      ST_ISSUE: begin
        // A monotonic stride that leaves the page never returns, so stop at the first miss.
        if (hs) begin
          if (last_k || !nxt_in_page) begin
            state_d      = ST_IDLE;
            pref_valid_d = 1'b0;
          end else begin
            cur_cla_d   = nxt_cla;
            k_d         = k_q + 1'b1;
            pref_addr_d = nxt_addr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IP_TRACKER_COUNT; i++) begin
        valid_q[i]       <= 1'b0;
        ip_q[i]          <= '0;
        last_cla_q[i]    <= '0;
        last_stride_q[i] <= '0;
        conf_q[i]        <= '0;
        age_q[i]         <= AGE_W'(i);
      end
      state_q      <= ST_IDLE;
      cur_cla_q    <= '0;
      stride_q     <= '0;
      page_q       <= '0;
      k_q          <= '0;
      pref_valid_q <= 1'b0;
      pref_addr_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      ip_q          <= ip_d;
      last_cla_q    <= last_cla_d;
      last_stride_q <= last_stride_d;
      conf_q        <= conf_d;
      age_q         <= age_d;
      state_q       <= state_d;
      cur_cla_q     <= cur_cla_d;
      stride_q      <= stride_d;
      page_q        <= page_d;
      k_q           <= k_d;
      pref_valid_q  <= pref_valid_d;
      pref_addr_q   <= pref_addr_d;
    end
  end

`ifdef IP_STRIDE_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(hs);
    drop_cnt_d  = drop_cnt_q;
    if (trigger && !cand1_in_page)     drop_cnt_d = drop_cnt_q + 32'(DEGREE);
    else if (hs && !last_k && !nxt_in_page)
      drop_cnt_d = drop_cnt_q + 32'(DEGREE) - 32'(k_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign pf_issue_cnt_o = issue_cnt_q;
  assign pf_drop_cnt_o  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ip_stride_multi.sv
// Scoreboard bench for ip_stride_multi: directed scenarios plus randomized multi-IP traffic
// checked against a behavioural tracker model (LRU kept as an ordered list of indices).
module tb_ip_stride_multi;
  localparam int N         = 16;
  localparam int DEG       = 4;
  localparam int CONF_MAX  = 3;
  localparam int THRESH    = 2;
  localparam logic [63:0] CLA_MASK = (64'd1 << 58) - 64'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
`ifdef IP_STRIDE_STATS_EN
  logic [31:0] issue_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  ip_stride_multi_if #(.ADDR_W(64)) bus ();

  ip_stride_multi dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef IP_STRIDE_STATS_EN
    .pf_issue_cnt_o (issue_cnt),
    .pf_drop_cnt_o  (drop_cnt),
`endif
    .dbg_state_o    (dbg_state),
    .bus            (bus)
  );

  logic [63:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int hs_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [N];
  logic [63:0] m_ip    [N];
  logic [63:0] m_cla   [N];
  logic [63:0] m_stride[N];
  int          m_conf  [N];
  int          lru[$];   // front = most recently used
  int          m_issued, m_dropped;

  function automatic void model_reset();
    lru.delete();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_ip[i] = '0; m_cla[i] = '0; m_stride[i] = '0; m_conf[i] = 0;
      lru.push_back(i);
    end
    m_issued = 0;
    m_dropped = 0;
    exp_q.delete();
  endfunction

  function automatic void model_touch(input int idx);
    for (int p = 0; p < lru.size(); p++) begin
      if (lru[p] == idx) begin
        lru.delete(p);
        break;
      end
    end
    lru.push_front(idx);
  endfunction

  function automatic void model_access(input logic [63:0] ip, input logic [63:0] addr);
    logic [63:0] cla, stride, page, c;
    int h, v;
    bit trig;
    cla = addr >> 6;
    page = addr >> 12;
    h = -1; v = -1; trig = 1'b0;
    for (int i = 0; i < N; i++) if (m_valid[i] && m_ip[i] == ip) h = i;
    if (h < 0) begin
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) v = lru[$];
      m_valid[v] = 1'b1; m_ip[v] = ip; m_cla[v] = cla; m_stride[v] = '0; m_conf[v] = 0;
      model_touch(v);
      return;
    end
    stride = (cla - m_cla[h]) & CLA_MASK;
    if (stride != 0) begin
      if (stride == m_stride[h]) begin
        if (m_conf[h] < CONF_MAX) m_conf[h]++;
        trig = (m_conf[h] >= THRESH);
      end else if (m_conf[h] > 0) begin
        m_conf[h]--;
      end
      m_cla[h] = cla;
      m_stride[h] = stride;
    end
    model_touch(h);
    if (trig) begin
      for (int k = 1; k <= DEG; k++) begin
        c = (cla + 64'(k) * stride) << 6;
        if ((c >> 12) != page) begin
          m_dropped += DEG - k + 1;
          break;
        end
        exp_q.push_back(c);
        m_issued++;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  bit          prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [63:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.pref_valid_o), 64'd1);
        check("hold_addr", bus.pref_addr_o, prev_addr);
      end
      check("req_ready", 64'(bus.req_ready_o), 64'(!bus.pref_valid_o));
      check("dbg_state", 64'(dbg_state), 64'(bus.pref_valid_o));
      if (bus.pref_valid_o && bus.pref_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pref_unexpected: got 0x%0h, required no candidate", bus.pref_addr_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pref_addr", bus.pref_addr_o, mon_exp);
        end
      end
      prev_stall = bus.pref_valid_o && !bus.pref_ready_i;
      prev_addr = bus.pref_addr_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] ip, input logic [63:0] addr);
    int n = 0;
    while (!bus.req_ready_o && n < 200) begin
      if (rand_ready) bus.pref_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready_o) begin
      checks++;
      $display("FAIL send_timeout: got req_ready 0 after %0d cycles, required 1", n);
      return;
    end
    if (rand_ready) bus.pref_ready_i = ($urandom_range(0, 3) != 0);
    bus.req_valid_i = 1'b1;
    bus.ip_i = ip;
    bus.addr_i = addr;
    model_access(ip, addr);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic burst_end(input string tag, input int n);
    repeat (n) begin @(posedge clk); #1; end
    check({tag, "_valid_low"}, 64'(bus.pref_valid_o), 64'd0);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef IP_STRIDE_STATS_EN
    check({tag, "_issue_cnt"}, 64'(issue_cnt), 64'(m_issued));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_dropped));
`else
    if (tag.len() == 0) $display("stats tag empty");
`endif
  endtask

  task automatic do_reset();
    bus.req_valid_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pref_valid", 64'(bus.pref_valid_o), 64'd0);
    check("rst_pref_addr", bus.pref_addr_o, 64'd0);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check_stats("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [63:0] slot_ip  [20];
  logic [63:0] slot_addr[20];
  int          slot_str [20];

  initial begin
    int base, n, s;
    bus.req_valid_i = 1'b0;
    bus.addr_i = '0;
    bus.ip_i = '0;
    bus.pref_ready_i = 1'b1;
    model_reset();

    // Positive stride
    do_reset();
    send(64'h400, 64'h1000);
    send(64'h400, 64'h1040);
    send(64'h400, 64'h1080);
    check("s1_no_early", 64'(bus.pref_valid_o), 64'd0);
    send(64'h400, 64'h10C0);
    check("s1_latency_valid", 64'(bus.pref_valid_o), 64'd1);
    check("s1_first_addr", bus.pref_addr_o, 64'h1100);
    burst_end("s1", 4);

    // Page clip
    send(64'h500, 64'h1D00);
    send(64'h500, 64'h1D80);
    send(64'h500, 64'h1E00);
    send(64'h500, 64'h1E80);
    check("s2_first_addr", bus.pref_addr_o, 64'h1F00);
    burst_end("s2", 2);
    check_stats("s2");

    // Negative stride
    send(64'h600, 64'h3300);
    send(64'h600, 64'h32C0);
    send(64'h600, 64'h3280);
    send(64'h600, 64'h3240);
    check("s3_first_addr", bus.pref_addr_o, 64'h3200);
    burst_end("s3", 4);

    // Backpressure with an ignored sample pulse
    do_reset();
    send(64'h400, 64'h1000);
    send(64'h400, 64'h1040);
    send(64'h400, 64'h1080);
    bus.pref_ready_i = 1'b0;
    send(64'h400, 64'h10C0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.pref_valid_o), 64'd1);
      check("bp_addr", bus.pref_addr_o, 64'h1100);
      check("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
      bus.req_valid_i = (i == 1);
      bus.ip_i = 64'h400;
      bus.addr_i = 64'h1100;
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    bus.pref_ready_i = 1'b1;
    burst_end("bp", 4);
    send(64'h400, 64'h1100);
    check("bp_retrigger_addr", bus.pref_addr_o, 64'h1140);
    burst_end("bp2", 4);

    // LRU replacement
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++)
        send(64'h7000 + 64'(i) * 64'h10, 64'h10_0000 * 64'(i + 1) + 64'(j) * 64'h40);
    send(64'h7000, 64'h10_00C0);
    check("lru_a_trigger", bus.pref_addr_o, 64'h10_0100);
    burst_end("lru_a", 4);
    send(64'h7100, 64'h200_0000);
    send(64'h7010, 64'h20_00C0);
    repeat (6) begin @(posedge clk); #1; end
    check("lru_b_evicted", 64'(bus.pref_valid_o), 64'd0);
    send(64'h7000, 64'h10_0100);
    check("lru_a_still_hits", bus.pref_addr_o, 64'h10_0140);
    burst_end("lru_a2", 4);
    send(64'h7030, 64'h40_00C0);
    check("lru_d_hits", bus.pref_addr_o, 64'h40_0100);
    burst_end("lru_d", 4);

    // Asynchronous reset during issue
    do_reset();
    send(64'h400, 64'h1000);
    send(64'h400, 64'h1040);
    send(64'h400, 64'h1080);
    base = hs_cnt;
    send(64'h400, 64'h10C0);
    n = 0;
    while (hs_cnt < base + 2 && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_two_handshakes", 64'(hs_cnt - base), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid_cleared", 64'(bus.pref_valid_o), 64'd0);
    check("ar_addr_cleared", bus.pref_addr_o, 64'd0);
    check("ar_req_ready", 64'(bus.req_ready_o), 64'd1);
    model_reset();
    check_stats("ar");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'h400, 64'h10C0);
    repeat (6) begin @(posedge clk); #1; end
    check("ar_replay_no_pref", 64'(bus.pref_valid_o), 64'd0);

    // Randomized multi-IP traffic with random backpressure
    do_reset();
    for (int i = 0; i < 20; i++) begin
      slot_ip[i] = 64'h9000 + 64'(i) * 64'h8;
      slot_addr[i] = 64'h10_0000 * 64'(i + 1) + 64'($urandom_range(0, 63)) * 64'h40;
      slot_str[i] = int'($urandom_range(0, 6)) - 3;
    end
    rand_ready = 1'b1;
    for (int t = 0; t < 400; t++) begin
      s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 19)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) slot_str[s] = int'($urandom_range(0, 6)) - 3;
      slot_addr[s] = slot_addr[s] + 64'(longint'(slot_str[s]) * 64);
      send(slot_ip[s], slot_addr[s]);
      repeat ($urandom_range(0, 2)) begin
        bus.pref_ready_i = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    bus.pref_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.pref_valid_o) && n < 100) begin @(posedge clk); #1; n++; end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(bus.pref_valid_o), 64'd0);
    check_stats("rand");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ip_stride_multi.md
# ip_stride_multi

Parametrised IP-indexed stride prefetcher, successor to the fixed-degree tracker. It adds per-tracker saturating confidence, true-LRU replacement with valid bits, and a configurable prefetch degree. Candidates leave through a serial valid/ready issue port, so it drops in between the L1 miss/access stream and the prefetch queue with backpressure.

## Interface
- IP_TRACKER_COUNT, 16, number of IP trackers (power of 2, ≥2)
- DEGREE, 4, max prefetches per trigger (1..8)
- CONF_BITS, 2, confidence counter width
- CONF_THRESH, 2, minimum confidence to trigger (≤ 2^CONF_BITS−1)
- ADDR_W, 64, address and IP width
- LOG2_BLOCK_SIZE, 6, cache line size log2
- LOG2_PAGE_SIZE, 12, page size log2
- clk  in  1  clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  access sample valid
- req_ready_o  out  1  block accepts sample; high iff FSM is IDLE
- addr_i  in  ADDR_W  accessed byte address
- ip_i  in  ADDR_W  instruction pointer of access
- pref_valid_o  out  1  prefetch candidate valid (registered)
- pref_addr_o  out  ADDR_W  line-aligned prefetch address (registered)
- pref_ready_i  in  1  consumer accepts candidate

## Operation
- Terms: cla = addr_i >> LOG2_BLOCK_SIZE, CLA_W = ADDR_W − LOG2_BLOCK_SIZE. Sample accepted = req_valid_i & req_ready_o.
- Tracker state: valid, ip, last_cla, last_stride (signed CLA_W), conf (CONF_BITS), age (clog2(IP_TRACKER_COUNT)).
- Lookup: hit = valid & ip == ip_i. More than one hit is impossible by construction.
- Miss: allocate victim. Victim is the lowest-index invalid entry, else the entry with age == IP_TRACKER_COUNT−1. Load ip, last_cla=cla, last_stride=0, conf=0, valid=1. Touch the entry.
- Hit: stride = cla − last_cla, two's-complement modulo 2^CLA_W.
  - stride==0: touch only; no other field changes.
  - stride!=0 and stride==last_stride: conf saturating +1.
  - stride!=0 and stride!=last_stride: conf saturating −1, floor 0.
  - On any nonzero stride: last_cla=cla, last_stride=stride.
- Trigger: hit, stride!=0, stride==last_stride, and updated conf ≥ CONF_THRESH.
- Touch (true LRU): entries whose age is below the touched age increment; the touched entry's age becomes 0. On reset, ages = index, so they always form a permutation.
- Issue FSM:
  - IDLE: on trigger, latch base=cla, stride, page=addr_i >> LOG2_PAGE_SIZE, k=1. Go to ISSUE only if candidate 1 is in-page.
  - ISSUE: pref_addr_o = (base + k·stride) << LOG2_BLOCK_SIZE, truncated to ADDR_W. On pref_valid_o & pref_ready_i, k++.
  - Return to IDLE when k reaches DEGREE or the next candidate's page ≠ page. Remaining candidates are dropped; the stride is monotonic, so none can re-enter the page.
- Samples are not accepted in ISSUE; req_valid_i is ignored there.

## Timing
- Reset values: pref_valid_o=0, pref_addr_o=0, req_ready_o=1 (IDLE), all valid=0, conf=0, last_*=0, age=index, FSM=IDLE.
- Tracker update, victim allocation and LRU touch take effect at the edge that accepts the sample.
- Latency: trigger sample accepted at edge N → pref_valid_o high in cycle N+1 with candidate 1. One candidate per cycle under pref_ready_i=1.
- pref_valid_o and pref_addr_o hold stable while pref_ready_i=0.
- Final handshake at edge M → pref_valid_o=0 and req_ready_o=1 in cycle M+1.
- rst_n low mid-ISSUE: outputs clear immediately (async). Trackers are invalidated and pending candidates are discarded.

## Configuration
- IP_STRIDE_STATS_EN defined: adds ports pf_issue_cnt_o (out, 32) and pf_drop_cnt_o (out, 32), both wrapping and reset to 0.
  - pf_issue_cnt_o counts issue handshakes.
  - pf_drop_cnt_o counts candidates discarded by the page check, i.e. DEGREE − issued for each trigger.
- IP_STRIDE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
Defaults except where stated; pref_ready_i=1 unless stated.
- Positive stride, ip 0x400, addrs 0x1000,0x1040,0x1080,0x10C0 → no output for the first three; after the fourth, 0x1100,0x1140,0x1180,0x11C0 on consecutive cycles.
- Page clip, ip 0x500, addrs 0x1D00,0x1D80,0x1E00,0x1E80 → 0x1F00,0x1F80 only, then IDLE. Drop count +2 with stats enabled.
- Negative stride, ip 0x600, addrs 0x3300,0x32C0,0x3280,0x3240 → 0x3200,0x31C0,0x3180,0x3140.
- Backpressure: scenario 1 with pref_ready_i=0 for 5 cycles after the trigger → 0x1100 held 5 cycles; req_ready_o=0; a req_valid_i pulse meanwhile leaves tracker state unchanged.
- LRU, IP_TRACKER_COUNT=4: ips A,B,C,D, then A, then E → E evicts B. A further access by B is a miss (no trigger possible until retrained). A still hits.
- Async reset: scenario 1, drop rst_n after two handshakes → pref_valid_o=0 immediately. Replaying 0x10C0 with ip 0x400 is a miss and produces no prefetch.
